// File: rtl/spu_pipe_pkg.sv
// Shared types and constants for the SPU result pipeline (ST3..ST7).
// Holds the stage entry layout plus latency helper functions.
package spu_pipe_pkg;

    localparam int NUM_STAGES  = 5;
    localparam int MAX_LATENCY = 4;
    localparam int REG_ADDR_W  = 7;
    localparam int DATA_W      = 128;
    localparam int LAT_W       = 3;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rt;
        logic                  we;
        logic [LAT_W-1:0]      lat;
        logic [DATA_W-1:0]     result;
    } stage_entry_t;

    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat,
                                                 input logic [LAT_W-1:0] max_lat);
        if (lat > max_lat) begin
            return max_lat;
        end else begin
            return lat;
        end
    endfunction

    function automatic logic [LAT_W-1:0] dec_lat(input logic [LAT_W-1:0] lat);
        if (lat != 3'd0) begin
            return lat - 3'd1;
        end else begin
            return 3'd0;
        end
    endfunction

endpackage

// File: rtl/result_stage.sv
// One pipeline entry register: holds under stall, optionally decrements the
// remaining latency of the incoming entry (saturating at zero) on advance.
module result_stage
    import spu_pipe_pkg::*;
#(
    parameter bit DECREMENT = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  stage_entry_t entry_i,
    output stage_entry_t entry_o
);

    stage_entry_t entry_d;
    stage_entry_t entry_q;

    // Next-state: take the upstream entry on advance, otherwise hold.
    always_comb begin
        entry_d = entry_q;
        if (!stall) begin
            entry_d = entry_i;
            if (DECREMENT) begin
                entry_d.lat = dec_lat(entry_i.lat);
            end else begin
                entry_d.lat = entry_i.lat;
            end
        end else begin
            entry_d = entry_q;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q.rt     <= 7'd0;
            entry_q.we     <= 1'b0;
            entry_q.lat    <= 3'd0;
            entry_q.result <= 128'd0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/result_pipeline.sv
// SPU result pipeline: five chained result_stage entries (ST3..ST7), a
// combinational register-file writeback port off ST7 and a sticky latency error.
module result_pipeline
    import spu_pipe_pkg::*;
#(
    parameter int MAX_LATENCY = spu_pipe_pkg::MAX_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush_EX,
    input  logic                  issueRegWriteEnable_EX,
    input  logic [REG_ADDR_W-1:0] issueRT_EX,
    input  logic [LAT_W-1:0]      issueLatency_EX,
    input  logic [DATA_W-1:0]     issueResult_EX,
    output logic [REG_ADDR_W-1:0] readRegisterRT_ST3,
    output logic [REG_ADDR_W-1:0] readRegisterRT_ST4,
    output logic [REG_ADDR_W-1:0] readRegisterRT_ST5,
    output logic [REG_ADDR_W-1:0] readRegisterRT_ST6,
    output logic [REG_ADDR_W-1:0] readRegisterRT_ST7,
    output logic                  regWriteEnable_ST3,
    output logic                  regWriteEnable_ST4,
    output logic                  regWriteEnable_ST5,
    output logic                  regWriteEnable_ST6,
    output logic                  regWriteEnable_ST7,
    output logic [LAT_W-1:0]      latency_ST3,
    output logic [LAT_W-1:0]      latency_ST4,
    output logic [LAT_W-1:0]      latency_ST5,
    output logic [LAT_W-1:0]      latency_ST6,
    output logic [LAT_W-1:0]      latency_ST7,
    output logic [DATA_W-1:0]     result_ST3,
    output logic [DATA_W-1:0]     result_ST4,
    output logic [DATA_W-1:0]     result_ST5,
    output logic [DATA_W-1:0]     result_ST6,
    output logic [DATA_W-1:0]     result_ST7,
    output logic                  rfWriteEnable,
    output logic [REG_ADDR_W-1:0] rfWriteAddr,
    output logic [DATA_W-1:0]     rfWriteData,
    output logic                  latencyError
);

    localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_LATENCY);

    stage_entry_t ex_entry_s;
    stage_entry_t stage_in_s [NUM_STAGES];
    stage_entry_t stage_q_s  [NUM_STAGES];
    logic         latency_error_d;
    logic         latency_error_q;

    // EX capture: flushed entries keep their payload but never write.
    always_comb begin
        ex_entry_s.rt     = issueRT_EX;
        ex_entry_s.we     = issueRegWriteEnable_EX & ~flush_EX;
        ex_entry_s.lat    = sat_lat(issueLatency_EX, MAX_LAT);
        ex_entry_s.result = issueResult_EX;
    end

    assign stage_in_s[0] = ex_entry_s;

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_stage
            if (g > 0) begin : g_link
                assign stage_in_s[g] = stage_q_s[g-1];
            end
            result_stage #(
                .DECREMENT ((g > 0) ? 1'b1 : 1'b0)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .stall   (stall),
                .entry_i (stage_in_s[g]),
                .entry_o (stage_q_s[g])
            );
        end
    endgenerate

    assign readRegisterRT_ST3 = stage_q_s[0].rt;
    assign readRegisterRT_ST4 = stage_q_s[1].rt;
    assign readRegisterRT_ST5 = stage_q_s[2].rt;
    assign readRegisterRT_ST6 = stage_q_s[3].rt;
    assign readRegisterRT_ST7 = stage_q_s[4].rt;
    assign regWriteEnable_ST3 = stage_q_s[0].we;
    assign regWriteEnable_ST4 = stage_q_s[1].we;
    assign regWriteEnable_ST5 = stage_q_s[2].we;
    assign regWriteEnable_ST6 = stage_q_s[3].we;
    assign regWriteEnable_ST7 = stage_q_s[4].we;
    assign latency_ST3        = stage_q_s[0].lat;
    assign latency_ST4        = stage_q_s[1].lat;
    assign latency_ST5        = stage_q_s[2].lat;
    assign latency_ST6        = stage_q_s[3].lat;
    assign latency_ST7        = stage_q_s[4].lat;
    assign result_ST3         = stage_q_s[0].result;
    assign result_ST4         = stage_q_s[1].result;
    assign result_ST5         = stage_q_s[2].result;
    assign result_ST6         = stage_q_s[3].result;
    assign result_ST7         = stage_q_s[4].result;

    // Writeback is combinational off ST7 and suppressed while stalled.
    always_comb begin
        rfWriteAddr = stage_q_s[NUM_STAGES-1].rt;
        rfWriteData = stage_q_s[NUM_STAGES-1].result;
        if (stage_q_s[NUM_STAGES-1].we && !stall && (stage_q_s[NUM_STAGES-1].lat == 3'd0)) begin
            rfWriteEnable = 1'b1;
        end else begin
            rfWriteEnable = 1'b0;
        end
    end

    // Sticky flag: set on an advancing, non-flushed write with an illegal latency.
    always_comb begin
        latency_error_d = latency_error_q;
        if (!stall && issueRegWriteEnable_EX && !flush_EX && (issueLatency_EX > MAX_LAT)) begin
            latency_error_d = 1'b1;
        end else begin
            latency_error_d = latency_error_q;
        end
    end

    // Latency error register.
    always_ff @(posedge clk) begin
        if (reset) begin
            latency_error_q <= 1'b0;
        end else begin
            latency_error_q <= latency_error_d;
        end
    end

    assign latencyError = latency_error_q;

endmodule

// File: tb/tb_result_pipeline.sv
// Directed self-checking bench for result_pipeline.
module tb_result_pipeline;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         flush_EX;
    logic         issueRegWriteEnable_EX;
    logic [6:0]   issueRT_EX;
    logic [2:0]   issueLatency_EX;
    logic [127:0] issueResult_EX;
    logic [6:0]   rt3, rt4, rt5, rt6, rt7;
    logic         we3, we4, we5, we6, we7;
    logic [2:0]   lat3, lat4, lat5, lat6, lat7;
    logic [127:0] res3, res4, res5, res6, res7;
    logic         rfWriteEnable;
    logic [6:0]   rfWriteAddr;
    logic [127:0] rfWriteData;
    logic         latencyError;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] PAT_AA = {16{8'hAA}};
    localparam logic [127:0] PAT_55 = {16{8'h55}};

    result_pipeline dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_EX(flush_EX),
        .issueRegWriteEnable_EX(issueRegWriteEnable_EX), .issueRT_EX(issueRT_EX),
        .issueLatency_EX(issueLatency_EX), .issueResult_EX(issueResult_EX),
        .readRegisterRT_ST3(rt3), .readRegisterRT_ST4(rt4), .readRegisterRT_ST5(rt5),
        .readRegisterRT_ST6(rt6), .readRegisterRT_ST7(rt7),
        .regWriteEnable_ST3(we3), .regWriteEnable_ST4(we4), .regWriteEnable_ST5(we5),
        .regWriteEnable_ST6(we6), .regWriteEnable_ST7(we7),
        .latency_ST3(lat3), .latency_ST4(lat4), .latency_ST5(lat5),
        .latency_ST6(lat6), .latency_ST7(lat7),
        .result_ST3(res3), .result_ST4(res4), .result_ST5(res5),
        .result_ST6(res6), .result_ST7(res7),
        .rfWriteEnable(rfWriteEnable), .rfWriteAddr(rfWriteAddr),
        .rfWriteData(rfWriteData), .latencyError(latencyError)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] rt, input logic we, input logic [2:0] lat,
                         input logic [127:0] res);
        issueRT_EX             = rt;
        issueRegWriteEnable_EX = we;
        issueLatency_EX        = lat;
        issueResult_EX         = res;
    endtask

    task automatic clear_ex();
        issue(7'd0, 1'b0, 3'd0, 128'd0);
        flush_EX = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        clear_ex();
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_we3", we3, 1'b0);
        check("rst_we7", we7, 1'b0);
        check("rst_rt3", rt3, 7'd0);
        check("rst_lat3", lat3, 3'd0);
        check("rst_res7", res7, 128'd0);
        check("rst_rfwe", rfWriteEnable, 1'b0);
        check("rst_lerr", latencyError, 1'b0);

        // Single issue, latency 2
        issue(7'd10, 1'b1, 3'd2, PAT_AA);
        step();
        clear_ex();
        check("s1_rt3", rt3, 7'd10);
        check("s1_we3", we3, 1'b1);
        check("s1_lat3", lat3, 3'd2);
        check("s1_res3", res3, PAT_AA);
        check("s1_rfwe_e1", rfWriteEnable, 1'b0);
        step();
        check("s1_lat4", lat4, 3'd1);
        check("s1_rfwe_e2", rfWriteEnable, 1'b0);
        step();
        check("s1_lat5", lat5, 3'd0);
        step();
        check("s1_lat6", lat6, 3'd0);
        check("s1_rfwe_e4", rfWriteEnable, 1'b0);
        step();
        check("s1_lat7", lat7, 3'd0);
        check("s1_rfwe_e5", rfWriteEnable, 1'b1);
        check("s1_rfaddr", rfWriteAddr, 7'd10);
        check("s1_rfdata", rfWriteData, PAT_AA);
        stall = 1'b1;
        #1;
        check("s1_rfwe_stalled", rfWriteEnable, 1'b0);
        stall = 1'b0;
        #1;
        step();
        check("s1_rfwe_e6", rfWriteEnable, 1'b0);

        // Stall while entry sits in ST4; EX inputs must be ignored
        issue(7'd10, 1'b1, 3'd2, PAT_AA);
        step();
        clear_ex();
        step();
        check("s2_lat4_pre", lat4, 3'd1);
        stall = 1'b1;
        issue(7'd99, 1'b1, 3'd7, {128{1'b1}});
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2_lat4_hold", lat4, 3'd1);
            check("s2_we4_hold", we4, 1'b1);
            check("s2_we3_hold", we3, 1'b0);
            check("s2_rfwe_stall", rfWriteEnable, 1'b0);
            check("s2_lerr_stall", latencyError, 1'b0);
        end
        stall = 1'b0;
        clear_ex();
        step();
        check("s2_lat5", lat5, 3'd0);
        step();
        check("s2_rfwe_e7", rfWriteEnable, 1'b0);
        step();
        check("s2_rfwe_e8", rfWriteEnable, 1'b1);
        check("s2_rfaddr", rfWriteAddr, 7'd10);
        step();

        // Flushed issue
        issue(7'd5, 1'b1, 3'd1, PAT_55);
        flush_EX = 1'b1;
        step();
        clear_ex();
        check("s3_rt3", rt3, 7'd5);
        check("s3_we3", we3, 1'b0);
        check("s3_lat3", lat3, 3'd1);
        check("s3_res3", res3, PAT_55);
        for (int i = 0; i < 4; i++) begin
            step();
            check("s3_rfwe", rfWriteEnable, 1'b0);
        end
        check("s3_rt7", rt7, 7'd5);
        check("s3_we7", we7, 1'b0);

        // Back-to-back same destination
        issue(7'd3, 1'b1, 3'd0, 128'd1);
        step();
        issue(7'd3, 1'b1, 3'd0, 128'd2);
        step();
        clear_ex();
        step();
        step();
        check("s4_rfwe_pre", rfWriteEnable, 1'b0);
        step();
        check("s4_rfwe_a", rfWriteEnable, 1'b1);
        check("s4_addr_a", rfWriteAddr, 7'd3);
        check("s4_data_a", rfWriteData, 128'd1);
        step();
        check("s4_rfwe_b", rfWriteEnable, 1'b1);
        check("s4_addr_b", rfWriteAddr, 7'd3);
        check("s4_data_b", rfWriteData, 128'd2);
        step();
        check("s4_rfwe_c", rfWriteEnable, 1'b0);

        // Illegal latency
        check("s5_lerr_pre", latencyError, 1'b0);
        issue(7'd20, 1'b1, 3'd6, 128'd7);
        step();
        clear_ex();
        check("s5_lerr", latencyError, 1'b1);
        check("s5_lat3", lat3, 3'd4);
        step();
        check("s5_lat4", lat4, 3'd3);
        step();
        step();
        step();
        check("s5_lat7", lat7, 3'd0);
        check("s5_rfwe", rfWriteEnable, 1'b1);
        step();
        check("s5_lerr_sticky", latencyError, 1'b1);

        // Mid-flight reset with stall and flush also high
        issue(7'd1, 1'b1, 3'd0, 128'd11);
        step();
        issue(7'd2, 1'b1, 3'd0, 128'd12);
        step();
        issue(7'd3, 1'b1, 3'd0, 128'd13);
        step();
        check("s6_we5_pre", we5, 1'b1);
        reset    = 1'b1;
        stall    = 1'b1;
        flush_EX = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        clear_ex();
        check("s6_we3", we3, 1'b0);
        check("s6_we4", we4, 1'b0);
        check("s6_we5", we5, 1'b0);
        check("s6_we6", we6, 1'b0);
        check("s6_we7", we7, 1'b0);
        check("s6_res5", res5, 128'd0);
        check("s6_lerr", latencyError, 1'b0);
        check("s6_rfwe_rst", rfWriteEnable, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("s6_rfwe_after", rfWriteEnable, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/result_pipeline.md
RESULT_PIPELINE -- requirements
Module: result_pipeline

Interface
REQ-001 SHALL have the following ports:
 - clk  in  1  single clock; rising edge.
 - reset  in  1  synchronous, active-high.
 - stall  in  1  freezes all stages when high.
 - flush_EX  in  1  kills the EX entry before capture.
 - issueRegWriteEnable_EX  in  1  EX instruction writes a register.
 - issueRT_EX  in  7  EX destination register.
 - issueLatency_EX  in  3  cycles until the result is forwardable; legal 0..4.
 - issueResult_EX  in  128  EX result data.
 - readRegisterRT_ST3..ST7  out  7 each  stage destination register.
 - regWriteEnable_ST3..ST7  out  1 each  stage write valid.
 - latency_ST3..ST7  out  3 each  remaining latency of stage entry.
 - result_ST3..ST7  out  128 each  stage result data.
 - rfWriteEnable  out  1  register-file write strobe.
 - rfWriteAddr  out  7  register-file write address.
 - rfWriteData  out  128  register-file write data.
 - latencyError  out  1  sticky illegal-latency flag.
REQ-002 SHALL use parameter NUM_STAGES, default 5, meaning ST3..ST7 depth; it is fixed and not user-overridable.
REQ-003 SHALL use parameter MAX_LATENCY, default 4, meaning the highest legal issue latency.

Function
REQ-004 SHALL advance the pipe on every clk edge with stall=0: EX→ST3, ST3→ST4, ST4→ST5, ST5→ST6, ST6→ST7; the ST7 entry retires.
REQ-005 SHALL, on advance, load ST3 as: rt=issueRT_EX, we=issueRegWriteEnable_EX & ~flush_EX, lat=issueLatency_EX saturated to MAX_LATENCY, result=issueResult_EX.
REQ-006 SHALL, on advance from STn to STn+1, set lat(n+1)=lat(n)-1 when lat(n)>0, else 0 (saturating).
REQ-007 SHALL pass rt, we and result unchanged from STn to STn+1.
REQ-008 SHALL, with stall=1, hold every stage field (including lat) and ignore all EX inputs.
REQ-009 SHALL drive rfWriteEnable = regWriteEnable_ST7 & ~stall & (latency_ST7==0), combinationally.
REQ-010 SHALL drive rfWriteAddr=readRegisterRT_ST7 and rfWriteData=result_ST7 at all times.
REQ-011 SHALL set latencyError to 1 at the advance edge where issueRegWriteEnable_EX=1, flush_EX=0 and issueLatency_EX>MAX_LATENCY; it stays 1 until reset.
REQ-012 SHALL not check for latencyError while stall=1.
REQ-013 SHALL, with flush_EX=1, still capture rt, lat and result into ST3 but with we=0; stages ST4..ST7 are unaffected.
REQ-014 SHALL allow the same rt in several stages simultaneously; every such entry retires in order.
REQ-015 SHALL guarantee lat=0 by ST7 for any legal issue latency (4 advances from ST3).
REQ-016 SHALL add zero latency on all outputs: stage outputs are direct register outputs and the writeback port is combinational from ST7.

Reset
REQ-017 SHALL, when reset=1 at a clk edge, clear every stage (we=0, rt=0, lat=0, result=0) and latencyError=0, regardless of stall or flush_EX.
REQ-018 SHALL discard any entry in flight when reset asserts mid-operation; no rfWriteEnable occurs in the cycle after reset.
REQ-019 SHALL drive rfWriteEnable=0 during and immediately after reset, since regWriteEnable_ST7=0.

Structure
REQ-020 SHALL place the following in shared package spu_pipe_pkg: typedef stage_entry_t {rt[6:0], we, lat[2:0], result[127:0]}, and constants NUM_STAGES=5, MAX_LATENCY=4, REG_ADDR_W=7, DATA_W=128.
REQ-021 SHALL implement each stage as an instance of sub-module result_stage (entry register with stall hold and saturating lat decrement), chained five times.
REQ-022 SHALL keep the writeback port and latencyError logic in the top level.

Verification
REQ-023 SHALL cover single issue: rt=10, we=1, lat=2, result=0xAA..AA, no stall → ST3 lat=2, ST4 lat=1, ST5..ST7 lat=0; rfWriteEnable=1 with addr 10 exactly 5 edges after issue.
REQ-024 SHALL cover stall: issue as above, stall=1 for 3 cycles while the entry is in ST4 → ST4 holds lat=1 for 3 cycles; writeback occurs 8 edges after issue; no write while stalled.
REQ-025 SHALL cover flush: issue rt=5, we=1 with flush_EX=1 → regWriteEnable_ST3..ST7=0 throughout; rfWriteEnable never asserts for that entry.
REQ-026 SHALL cover back-to-back same register: rt=3 issued on cycles 0 and 1 with results 1 and 2 → rf writes data 1 then 2 on consecutive cycles, addr 3.
REQ-027 SHALL cover illegal latency: issueLatency_EX=6, we=1 → latencyError=1 next cycle and sticky; ST3 lat=4; ST7 lat=0.
REQ-028 SHALL cover mid-flight reset: 3 entries in flight, reset pulsed 1 cycle → all regWriteEnable_STx=0, latencyError=0; no rf write follows.
